pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline stage register that replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 8-bit core. It carries a control bundle and a data bundle with valid/ready flow control, synchronous flush, and an optional two-entry skid buffer that breaks the combinational ready path. It also keeps a saturating back-pressure counter for performance analysis.

---
 rtl/pipe_stage_reg.sv | 180 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register for the 8-bit core.
// It carries a control bundle and a data bundle with valid/ready flow control,
// a synchronous flush, control gating on bubbles and a saturating stall counter.
// Build option PIPE_SKID_EN: when defined, the stage is a two-entry skid buffer
// with a registered in_ready. When undefined, the stage holds a single entry and
// in_ready is combinational.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       CTRL_W   = 12,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;
    logic              w_out_valid;
    logic              w_stall;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_stall     = w_out_valid & ~out_ready;

`ifdef PIPE_SKID_EN
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    // in_ready depends only on the state register, so out_ready never reaches it
    assign in_ready = (r_state != ST_FULL);

    // Next state and load selects for the two-entry skid buffer
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (!flush) begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        w_load_main_in = 1'b1;
                        w_state_nxt    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_valid && out_ready) begin
                        w_load_main_in = 1'b1;
                    end else if (in_valid) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (out_ready) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        w_load_main_skid = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end else begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Skid entry captures the input that arrives while the output is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_ctrl <= CTRL_RST;
            r_skid_data <= '0;
        end else if (flush) begin
            r_skid_ctrl <= CTRL_RST;
        end else if (w_load_skid) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
        end
    end
`else
    // Single entry: accept when empty or when the held entry leaves this cycle
    assign in_ready = ~w_out_valid | out_ready;

    // Next state and load select for the single-entry register
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (!flush) begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        w_load_main_in = 1'b1;
                        w_state_nxt    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_valid && out_ready) begin
                        w_load_main_in = 1'b1;
                    end else if (out_ready) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end else begin
            w_state_nxt = ST_EMPTY;
        end
    end
`endif

    // State register; flush is folded into the next-state logic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main entry: loads from the input or, in skid builds, from the skid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_ctrl <= CTRL_RST;
            r_main_data <= '0;
        end else if (flush) begin
            r_main_ctrl <= CTRL_RST;
        end else if (w_load_main_in) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
`ifdef PIPE_SKID_EN
        end else if (w_load_main_skid) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
`endif
        end
    end

    // Saturating back-pressure counter; clear beats increment, flush leaves it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid = w_out_valid;
    assign out_ctrl  = w_out_valid ? r_main_ctrl : CTRL_RST;
    assign out_data  = r_main_data;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (either build of PIPE_SKID_EN).
// A queue scoreboard models the held entries; a table drives the stream case.
module tb_pipe_stage_reg;

    localparam logic [11:0] CRST = 12'h0F0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_ctrl = '0;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_ctrl;
    logic [15:0] out_data;
    logic        clr_cnt = 1'b0;
    logic [3:0]  stall_cnt;

    pipe_stage_reg #(
        .DATA_W   (16),
        .CTRL_W   (12),
        .CTRL_RST (CRST),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .clr_cnt   (clr_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] c;
        logic [15:0] d;
    } ent_t;

    typedef struct {
        bit          iv;
        bit          ordy;
        logic [11:0] c;
        logic [15:0] d;
        bit          exp_ov;
        bit          exp_ir;
    } vec_t;

    ent_t q[$];
    int   m_cnt = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check and update model 1 time unit before posedge
    task automatic step(input bit iv, input bit ordy, input bit fl, input bit cl,
                        input logic [11:0] c, input logic [15:0] d,
                        output bit s_ov, output bit s_ir);
        bit   mv;
        bit   mr;
        ent_t e;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        clr_cnt   = cl;
        in_ctrl   = c;
        in_data   = d;
        #4;
        mv = (q.size() != 0);
`ifdef PIPE_SKID_EN
        mr = (q.size() < 2);
`else
        mr = !mv || ordy;
`endif
        chk("out_valid", out_valid, mv);
        chk("in_ready", in_ready, mr);
        if (mv) begin
            chk("out_ctrl", out_ctrl, q[0].c);
            chk("out_data", out_data, q[0].d);
        end else begin
            chk("out_ctrl_bubble", out_ctrl, CRST);
        end
        chk("stall_cnt", stall_cnt, m_cnt);
        s_ov = out_valid;
        s_ir = in_ready;
        if (fl) begin
            q.delete();
        end else begin
            if (mv && ordy) e = q.pop_front();
            if (iv && mr) q.push_back({c, d});
        end
        if (cl) m_cnt = 0;
        else if (mv && !ordy && m_cnt != 15) m_cnt++;
    endtask

    vec_t tbl[10];
    bit   ov;
    bit   ir;

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl", out_ctrl, CRST);
        chk("rst_out_data", out_data, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Stream with out_ready=1: table of expected handshake flags
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 1'b1, 12'h0A5, 16'(i + 1), (i != 0), 1'b1};
        tbl[8] = '{1'b0, 1'b1, 12'h000, 16'h0000, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 12'h000, 16'h0000, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].iv, tbl[i].ordy, 1'b0, 1'b0, tbl[i].c, tbl[i].d, ov, ir);
            chk("tbl_out_valid", ov, tbl[i].exp_ov);
            chk("tbl_in_ready", ir, tbl[i].exp_ir);
        end
        #2;
        chk("stream_stall_cnt", stall_cnt, 0);

`ifdef PIPE_SKID_EN
        // Back-pressure: two entries held, in_ready drops, order preserved
        step(1'b0, 1'b1, 1'b0, 1'b1, 12'h0, 16'h0, ov, ir);
        step(1'b1, 1'b0, 1'b0, 1'b0, 12'h021, 16'h0021, ov, ir);
        step(1'b1, 1'b0, 1'b0, 1'b0, 12'h022, 16'h0022, ov, ir);
        step(1'b1, 1'b0, 1'b0, 1'b0, 12'h023, 16'h0023, ov, ir);
        chk("skid_full_in_ready", ir, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 12'h023, 16'h0023, ov, ir);
        step(1'b1, 1'b1, 1'b0, 1'b0, 12'h024, 16'h0024, ov, ir);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 16'h0, ov, ir);
        // Fill to FULL before the flush
        step(1'b1, 1'b0, 1'b0, 1'b0, 12'h111, 16'h1111, ov, ir);
`endif
        // Flush with a new entry offered: the offered entry must never appear
        step(1'b1, 1'b0, 1'b0, 1'b0, 12'h112, 16'h1112, ov, ir);
        step(1'b1, 1'b0, 1'b1, 1'b0, 12'hDEA, 16'hDEAD, ov, ir);
        #2;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_ctrl", out_ctrl, CRST);
        chk("flush_in_ready", in_ready, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 12'h0, 16'h0, ov, ir);

        // Counter saturation at 15 after 20 stalled cycles, then clear vs stall
        step(1'b1, 1'b0, 1'b0, 1'b0, 12'h033, 16'h0033, ov, ir);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, ov, ir);
        #2;
        chk("cnt_saturated", stall_cnt, 15);
        step(1'b0, 1'b0, 1'b0, 1'b1, 12'h0, 16'h0, ov, ir);
        #2;
        chk("cnt_clr_wins", stall_cnt, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0, ov, ir);

        // Asynchronous reset between edges while holding one entry
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_ctrl", out_ctrl, CRST);
        chk("arst_out_data", out_data, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        chk("arst_in_ready", in_ready, 1);
        #1;
        rst = 1'b0;
        q.delete();
        m_cnt = 0;

        // out_ready toggling every cycle with continuous input
        for (int i = 0; i < 12; i++)
            step(1'b1, (i % 2) == 0, 1'b0, 1'b0, 12'(12'h040 + i), 16'(16'h4000 + i), ov, ir);

        // Random traffic with occasional flush and counter clear
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                 12'($urandom), 16'($urandom), ov, ir);

        // Drain
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 16'h0, ov, ir);
        chk("scoreboard_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
